// File: rtl/disp_pkg.sv
// Shared constants, shadow-register record and nibble helper for the display scanner.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [7:0]  AN_OFF     = 8'hFF;

  // Latched copy of the host-facing display request
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  pt;
    logic [7:0]  blk;
    logic [7:0]  bln;
  } shadow_t;

  // Select digit idx (digit 0 is the least significant nibble)
  function automatic logic [3:0] nibble_sel(input logic [31:0] data, input logic [2:0] idx);
    return data[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Free-running slot prescaler: end-of-slot tick and start-of-slot dead window.
module disp_prescaler #(
  parameter int unsigned DIV_BITS = 17,
  parameter int unsigned DEAD_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick,
  output logic o_dead
);

  logic [DIV_BITS-1:0] r_div_cnt;

  // Counter wraps naturally at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_tick = &r_div_cnt;
  assign o_dead = (r_div_cnt < DIV_BITS'(DEAD_CYC));

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller feeding an external hex-to-segment decoder.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DIV_BITS     = 17,
  parameter int unsigned DEAD_CYC     = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] disp_data,
  input  logic [7:0]  point_in,
  input  logic [7:0]  blank_in,
  input  logic [7:0]  blink_in,
  input  logic        lz_en,
  output logic [7:0]  AN,
  output logic [3:0]  hex,
  output logic        point,
  output logic        LE,
  output logic        frame_sync
);

  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic              w_tick;
  logic              w_dead;
  logic              w_frame_wrap;
  logic [7:0]        w_lz;
  shadow_t           r_shadow;
  logic [2:0]        r_scan_idx;
  logic [BlinkW-1:0] r_blink_cnt;
  logic              r_blink_phase;

  disp_prescaler #(
    .DIV_BITS (DIV_BITS),
    .DEAD_CYC (DEAD_CYC)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick),
    .o_dead (w_dead)
  );

  assign w_frame_wrap = w_tick & (r_scan_idx == 3'(NUM_DIGITS - 1));

  // Capture the host request; holds between load strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (load) begin
      r_shadow <= '{data: disp_data, pt: point_in, blk: blank_in, bln: blink_in};
    end
  end

  // Advance to the next digit at the end of each slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_idx <= '0;
    end else if (w_tick) begin
      r_scan_idx <= r_scan_idx + 3'd1;
    end
  end

  // Count whole frames and flip the blink phase every BLINK_FRAMES frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame_wrap) begin
      if (r_blink_cnt == BlinkW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Leading-zero mask: digit i>=1 is suppressible when it and every higher digit is zero
  always_comb begin
    logic zero_above;
    w_lz       = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (nibble_sel(r_shadow.data, 3'(i)) == 4'h0);
      w_lz[i]    = zero_above;
    end
  end

  // Registered outputs for the digit currently being scanned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AN         <= AN_OFF;
      hex        <= 4'h0;
      point      <= 1'b0;
      LE         <= 1'b1;
      frame_sync <= 1'b0;
    end else begin
      AN         <= w_dead ? AN_OFF : ~(8'b1 << r_scan_idx);
      hex        <= nibble_sel(r_shadow.data, r_scan_idx);
      point      <= r_shadow.pt[r_scan_idx];
      LE         <= r_shadow.blk[r_scan_idx]
                  | (r_shadow.bln[r_scan_idx] & r_blink_phase)
                  | (lz_en & w_lz[r_scan_idx]);
      frame_sync <= w_frame_wrap;
    end
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-digit common-anode 7-segment board.
- Latches a 32-bit display word plus per-digit point, blank and blink masks.
- Walks the digits at a divided rate and presents one nibble at a time to the downstream hex-to-segment decoder on hex/point/LE.
- Drives the active-low digit anodes, with dead-time between digits to suppress ghosting.

Parameters:
- DIV_BITS, 17, prescaler width; one digit slot lasts 2^DIV_BITS clocks.
- DEAD_CYC, 2, clocks at the start of each slot during which all anodes are off; must be < 2^DIV_BITS.
- BLINK_FRAMES, 64, full 8-digit frames per blink half-period.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  capture strobe for disp_data/point_in/blank_in/blink_in
- disp_data  in  32  digit i = disp_data[4i+3:4i]; digit 0 is rightmost
- point_in  in  8  per-digit decimal point request, active-high
- blank_in  in  8  per-digit forced blank, active-high
- blink_in  in  8  per-digit blink enable
- lz_en  in  1  leading-zero suppression enable, live and not latched
- AN  out  8  digit anode enables, active-low, one-hot-low or all-high
- hex  out  4  nibble for the current digit, to decoder D
- point  out  1  decimal point for the current digit, active-high; the decoder inverts it
- LE  out  1  blank the current digit, active-high
- frame_sync  out  1  one-clock pulse when scan_idx wraps 7->0

Behaviour:
- Reset (async, rst=1):
  - div_cnt=0, scan_idx=0, blink_cnt=0, blink_phase=0, shadow registers=0.
  - AN=8'hFF, hex=0, point=0, LE=1, frame_sync=0.
- Shadow capture:
  - When load=1 at a clk edge, data_r, pt_r, blk_r and bln_r take the inputs.
  - Otherwise they hold.
  - A load mid-slot updates the current digit's outputs on the following edge; there is no wait for the slot boundary.
- Prescaler:
  - div_cnt increments every clk and wraps at 2^DIV_BITS-1.
  - tick = (div_cnt == all ones).
- Scan:
  - On tick, scan_idx <= scan_idx+1, mod 8.
  - frame_sync is registered high for one clock on the tick where scan_idx==7.
- Blink:
  - On each frame wrap, blink_cnt increments.
  - When blink_cnt == BLINK_FRAMES-1, blink_cnt <= 0 and blink_phase toggles.
- Leading-zero mask, combinational on data_r:
  - lz[i]=1 for every digit i>=1 where digit i and all higher digits are 0.
  - Digit 0 is never in the mask.
- Output registers: all outputs registered, one-clock latency from scan_idx/div_cnt/shadow state.
  - hex <= data_r nibble[scan_idx].
  - point <= pt_r[scan_idx].
  - LE <= blk_r[scan_idx] | (bln_r[scan_idx] & blink_phase) | (lz_en & lz[scan_idx]).
  - AN <= 8'hFF while div_cnt < DEAD_CYC; otherwise AN <= ~(8'b1 << scan_idx).
- Boundary conditions:
  - A slot boundary tick and load in the same cycle are both honoured: the new slot shows the new data.
  - disp_data = 0 with lz_en shows "0" on digit 0 only.
  - When rst deasserts, the first enabled anode appears at div_cnt==DEAD_CYC (AN=8'hFE).
  - Reset mid-slot forces AN=8'hFF immediately, asynchronously.

Decomposition:
- Shared package disp_pkg holds:
  - NUM_DIGITS=8
  - AN_OFF=8'hFF
  - a function nibble_sel(data, idx)
- One natural sub-module, disp_prescaler: div_cnt, tick and dead-window flag, parameterised by DIV_BITS and DEAD_CYC.
- Scan, blink, masking and output registers stay in the top.

Test Plan (DIV_BITS=3, DEAD_CYC=2, BLINK_FRAMES=2 for simulation):
- Reset then load 32'h12345678, no masks:
  - slot k shows AN=~(1<<k) from the 3rd clock of the slot.
  - hex sequence 8,7,6,5,4,3,2,1.
  - LE=0 throughout.
  - frame_sync pulses every 64 clk.
- Dead-time: check AN=8'hFF for exactly 2 clocks at each slot start, and never two anodes low.
- Masks, with point_in=8'h04 and blank_in=8'h80:
  - point=1 only in slot 2.
  - LE=1 only in slot 7, whose hex still shows 1.
- Leading zeros, load 32'h00000A05 with lz_en=1:
  - LE=1 in slots 3..7.
  - LE=0 in slots 0..2.
  - Load 0: only slot 0 unblanked, hex=0.
- Blink, blink_in=8'h01:
  - slot 0 LE alternates 0 for 2 frames, then 1 for 2 frames.
  - Other digits are unaffected.
- Async reset mid-slot 5:
  - AN=8'hFF and LE=1 before the next clk edge.
  - After release, the scan restarts at slot 0 with the shadow data cleared.
